// File: rtl/lzc_pkg.sv
// lzc_pkg: shared state encoding and default sizing for the LZC
// job scheduler.
package lzc_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FEED,
      ST_WAIT,
      ST_PAD,
      ST_DONE
   } state_t;

   localparam int LZC_WIDTH = 16;
   localparam int LZC_WORD  = 16;
   localparam int LZC_ZW    = 9;
   localparam int LZC_TMO   = 64;
   localparam int LZC_CW    = $clog2(LZC_WORD + 1);
   localparam int LZC_TW    = $clog2(LZC_TMO + 1);

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, searching upward from
// i_ptr+1 and wrapping, so the last winner gets lowest priority.
module rr_arbiter #(
   parameter int NREQ = 4,
   parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic [NREQ-1:0] i_req,
   input  logic [PW-1:0]   i_ptr,
   output logic [NREQ-1:0] o_win
);

   logic          w_hit;
   logic [PW-1:0] w_idx;

   always_comb begin
      o_win = '0;
      w_hit = 1'b0;
      w_idx = '0;
      for (int k = 1; k <= NREQ; k++) begin
         w_idx = PW'((int'(i_ptr) + k) % NREQ);
         if (!w_hit && i_req[w_idx]) begin
            o_win[w_idx] = 1'b1;
            w_hit        = 1'b1;
         end
      end
   end

endmodule

// File: rtl/lzc_sched.sv
// lzc_sched: round-robin owner of one shared LZC; streams a WORD-word
// job per grant and hands the LZC result back to the owning requester.
module lzc_sched
   import lzc_pkg::*;
#(
   parameter int WIDTH = LZC_WIDTH,
   parameter int WORD  = LZC_WORD,
   parameter int NREQ  = 4,
   parameter int ZW    = LZC_ZW,
   parameter int TMO   = LZC_TMO
) (
   input  logic                  CLK,
   input  logic                  RST_N,
   input  logic [NREQ-1:0]       REQ,
   input  logic [NREQ-1:0]       REQ_MODE,
   input  logic [NREQ-1:0]       REQ_VALID,
   input  logic [NREQ*WIDTH-1:0] REQ_DATA,
   output logic [NREQ-1:0]       GNT,
   output logic [NREQ-1:0]       WORD_ACK,
   output logic                  L_IVALID,
   output logic [WIDTH-1:0]      L_DATA,
   output logic                  L_MODE,
   input  logic                  L_OVALID,
   input  logic [ZW-1:0]         L_ZEROS,
   output logic [NREQ-1:0]       RES_VALID,
   output logic [ZW-1:0]         RES_ZEROS,
   output logic                  RES_ERR,
   output logic                  BUSY
);

   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int CW = $clog2(WORD + 1);
   localparam int TW = $clog2(TMO + 1);

   state_t           r_state;
   state_t           w_state_nx;
   logic [NREQ-1:0]  r_gnt;
   logic [NREQ-1:0]  w_win;
   logic [PW-1:0]    r_ptr;
   logic [PW-1:0]    w_win_idx;
   logic [CW-1:0]    r_cnt;
   logic [TW-1:0]    r_tmr;
   logic             r_mode;
   logic             r_disc;
   logic             r_err;
   logic             r_ivalid;
   logic [WIDTH-1:0] r_data;
   logic [WIDTH-1:0] w_word;
   logic [ZW-1:0]    r_zeros;
   logic             w_own;
   logic             w_xfer;
   logic             w_last;
   logic             w_tmo;
   logic             w_done;

   rr_arbiter #(
      .NREQ (NREQ),
      .PW   (PW)
   ) u_arb (
      .i_req (REQ),
      .i_ptr (r_ptr),
      .o_win (w_win)
   );

   assign w_own  = |(r_gnt & REQ);
   assign w_xfer = (r_state == ST_FEED) && w_own
                && |(r_gnt & REQ_VALID);
   assign w_last = (r_cnt == CW'(WORD - 1));
   assign w_tmo  = (r_tmr == TW'(TMO));
   assign w_done = (r_state == ST_DONE);

   always_comb begin
      w_word    = '0;
      w_win_idx = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (r_gnt[i]) w_word = w_word | REQ_DATA[i*WIDTH +: WIDTH];
         if (w_win[i]) w_win_idx = PW'(i);
      end
   end

   always_comb begin
      w_state_nx = r_state;
      unique case (r_state)
         ST_IDLE: if (|REQ) w_state_nx = ST_FEED;
         ST_FEED: begin
            if (!w_own)               w_state_nx = ST_PAD;
            else if (w_xfer && w_last) w_state_nx = ST_WAIT;
         end
         ST_PAD:  if (w_last) w_state_nx = ST_WAIT;
         ST_WAIT: if (L_OVALID || w_tmo) w_state_nx = ST_DONE;
         ST_DONE: w_state_nx = ST_IDLE;
         default: w_state_nx = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) r_state <= ST_IDLE;
      else        r_state <= w_state_nx;
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_gnt    <= '0;
         r_ptr    <= PW'(NREQ - 1);
         r_cnt    <= '0;
         r_tmr    <= '0;
         r_mode   <= 1'b0;
         r_disc   <= 1'b0;
         r_err    <= 1'b0;
         r_ivalid <= 1'b0;
         r_data   <= '0;
         r_zeros  <= '0;
      end else begin
         // padding keeps the LZC frame length fixed after an abort
         r_ivalid <= w_xfer || (r_state == ST_PAD);
         if (w_xfer)                   r_data <= w_word;
         else if (r_state == ST_PAD)   r_data <= '0;
         unique case (r_state)
            ST_IDLE: if (|REQ) begin
               r_gnt  <= w_win;
               r_ptr  <= w_win_idx;
               r_mode <= |(w_win & REQ_MODE);
               r_cnt  <= '0;
               r_disc <= 1'b0;
            end
            ST_FEED: if (w_xfer) begin
               r_cnt <= r_cnt + CW'(1);
               if (w_last) r_tmr <= '0;
            end
            ST_PAD: begin
               r_cnt <= r_cnt + CW'(1);
               if (w_last) begin
                  r_tmr  <= '0;
                  r_disc <= 1'b1;
               end
            end
            ST_WAIT: begin
               r_tmr <= r_tmr + TW'(1);
               if (L_OVALID) begin
                  r_zeros <= L_ZEROS;
                  r_err   <= 1'b0;
               end else if (w_tmo) begin
                  r_zeros <= '0;
                  r_err   <= 1'b1;
               end
            end
            ST_DONE: r_gnt <= '0;
            default: ;
         endcase
      end
   end

   assign GNT       = r_gnt;
   assign WORD_ACK  = w_xfer ? r_gnt : '0;
   assign L_IVALID  = r_ivalid;
   assign L_DATA    = r_data;
   assign L_MODE    = r_mode;
   assign RES_VALID = (w_done && !r_disc) ? r_gnt : '0;
   assign RES_ZEROS = w_done ? r_zeros : '0;
   assign RES_ERR   = w_done && r_err;
   assign BUSY      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_lzc_sched.sv
// tb_lzc_sched: directed checks of lzc_sched driving a small
// frame-counting LZC model.
module tb_lzc_sched;

   localparam int WIDTH = 16;
   localparam int NREQ  = 4;
   localparam int ZW    = 9;

   logic                  CLK = 1'b0;
   logic                  RST_N = 1'b0;
   logic [NREQ-1:0]       REQ = '0;
   logic [NREQ-1:0]       REQ_MODE = '0;
   logic [NREQ-1:0]       REQ_VALID = '0;
   logic [NREQ*WIDTH-1:0] REQ_DATA = '0;
   logic [NREQ-1:0]       GNT;
   logic [NREQ-1:0]       WORD_ACK;
   logic                  L_IVALID;
   logic [WIDTH-1:0]      L_DATA;
   logic                  L_MODE;
   logic                  L_OVALID = 1'b0;
   logic [ZW-1:0]         L_ZEROS = '0;
   logic [NREQ-1:0]       RES_VALID;
   logic [ZW-1:0]         RES_ZEROS;
   logic                  RES_ERR;
   logic                  BUSY;

   int checks = 0;
   int failures = 0;

   int m_cnt = 0;
   int m_dly = 0;
   int m_lat = 2;

   int   cyc = 0;
   int   n_iv, n_nz, n_z, n_ack, n_res;
   int   t_first_iv, t_last_iv, t_res;
   int   mode_bad, mirror_bad;
   logic prev_ack = 1'b0;

   int   k;
   int   a0;
   logic seen_idle;
   logic [3:0] rot [5];

   lzc_sched u_dut (
      .CLK       (CLK),
      .RST_N     (RST_N),
      .REQ       (REQ),
      .REQ_MODE  (REQ_MODE),
      .REQ_VALID (REQ_VALID),
      .REQ_DATA  (REQ_DATA),
      .GNT       (GNT),
      .WORD_ACK  (WORD_ACK),
      .L_IVALID  (L_IVALID),
      .L_DATA    (L_DATA),
      .L_MODE    (L_MODE),
      .L_OVALID  (L_OVALID),
      .L_ZEROS   (L_ZEROS),
      .RES_VALID (RES_VALID),
      .RES_ZEROS (RES_ZEROS),
      .RES_ERR   (RES_ERR),
      .BUSY      (BUSY)
   );

   always #5 CLK = ~CLK;

   // LZC model: result m_lat cycles after the 16th word of a frame
   always @(posedge CLK) begin
      #1;
      if (!RST_N) begin
         m_cnt    = 0;
         m_dly    = 0;
         L_OVALID = 1'b0;
         L_ZEROS  = '0;
      end else begin
         L_OVALID = 1'b0;
         L_ZEROS  = '0;
         if (m_dly > 0) begin
            m_dly--;
            if (m_dly == 0) begin
               L_OVALID = 1'b1;
               L_ZEROS  = 9'd52;
            end
         end
         if (L_IVALID) begin
            m_cnt++;
            if (m_cnt == 16) begin
               m_cnt = 0;
               m_dly = m_lat;
            end
         end
      end
   end

   always @(negedge CLK) begin
      cyc++;
      if (L_IVALID) begin
         if (n_iv == 0) t_first_iv = cyc;
         n_iv++;
         t_last_iv = cyc;
         if (L_DATA != '0) n_nz++;
         else              n_z++;
         if (L_MODE !== |(GNT & REQ_MODE)) mode_bad++;
      end
      if (L_IVALID !== prev_ack) mirror_bad++;
      prev_ack = |WORD_ACK;
      n_ack += $countones(WORD_ACK);
      if (RES_VALID != '0) begin
         n_res++;
         t_res = cyc;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drv();
      @(posedge CLK);
      #1;
   endtask

   task automatic tick();
      @(negedge CLK);
      #1;
   endtask

   task automatic clr();
      n_iv = 0; n_nz = 0; n_z = 0; n_ack = 0; n_res = 0;
      t_first_iv = 0; t_last_iv = 0; t_res = 0;
      mode_bad = 0; mirror_bad = 0;
   endtask

   task automatic do_reset();
      RST_N     = 1'b0;
      REQ       = '0;
      REQ_VALID = '0;
      REQ_MODE  = '0;
      REQ_DATA  = '0;
      repeat (2) @(posedge CLK);
      #1 RST_N = 1'b1;
   endtask

   task automatic wait_res(input string tag, input int lim);
      int n;
      n = 0;
      do begin
         tick();
         n++;
      end while (RES_VALID == '0 && n < lim);
      chk({tag, "_seen"}, 32'(RES_VALID != '0), 32'd1);
   endtask

   task automatic chk_zero(input string p);
      chk({p, "_gnt"},  32'(GNT), 32'd0);
      chk({p, "_ack"},  32'(WORD_ACK), 32'd0);
      chk({p, "_lctl"}, 32'({L_IVALID, L_MODE}), 32'd0);
      chk({p, "_ldat"}, 32'(L_DATA), 32'd0);
      chk({p, "_res"},  32'({RES_VALID, RES_ERR}), 32'd0);
      chk({p, "_rz"},   32'(RES_ZEROS), 32'd0);
      chk({p, "_busy"}, 32'(BUSY), 32'd0);
   endtask

   initial begin
      rot = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      clr();

      // reset state
      repeat (2) @(posedge CLK);
      #1;
      chk_zero("rst");
      RST_N = 1'b1;

      // single job, mode 1
      drv();
      REQ_DATA[0 +: 16] = 16'h1234;
      REQ_MODE = 4'b0001;
      REQ_VALID = 4'b0001;
      REQ = 4'b0001;
      clr();
      tick();
      chk("t1_pre_gnt", 32'(GNT), 32'd0);
      tick();
      chk("t1_gnt", 32'(GNT), 32'd1);
      chk("t1_busy", 32'(BUSY), 32'd1);
      wait_res("t1", 200);
      chk("t1_res", 32'(RES_VALID), 32'b0001);
      chk("t1_zeros", 32'(RES_ZEROS), 32'd52);
      chk("t1_err", 32'(RES_ERR), 32'd0);
      chk("t1_iv", 32'(n_iv), 32'd16);
      chk("t1_run", 32'(t_last_iv - t_first_iv), 32'd15);
      chk("t1_ack", 32'(n_ack), 32'd16);
      chk("t1_lmode", 32'(L_MODE), 32'd1);
      chk("t1_ldata", 32'(L_DATA), 32'h1234);
      chk("t1_lat", 32'(t_res - t_last_iv), 32'd3);
      chk("t1_modebad", 32'(mode_bad), 32'd0);
      drv();
      REQ = '0;
      REQ_VALID = '0;
      tick();
      chk("t1_idle", 32'(BUSY), 32'd0);

      // rotation with all requesters active
      do_reset();
      REQ_DATA = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
      REQ_MODE = 4'b0101;
      REQ_VALID = 4'hF;
      REQ = 4'hF;
      clr();
      for (int j = 0; j < 5; j++) begin
         a0 = n_ack;
         wait_res("t2", 200);
         chk("t2_res", 32'(RES_VALID), 32'(rot[j]));
         chk("t2_gnt", 32'(GNT), 32'(rot[j]));
         chk("t2_ack", 32'(n_ack - a0), 32'd16);
      end
      drv();
      REQ = '0;
      REQ_VALID = '0;
      chk("t2_modebad", 32'(mode_bad), 32'd0);
      chk("t2_nres", 32'(n_res), 32'd5);

      // bubbles on requester 2
      do_reset();
      REQ_DATA[32 +: 16] = 16'h0F0F;
      REQ_VALID = 4'b0100;
      REQ = 4'b0100;
      clr();
      k = 0;
      while (RES_VALID == '0 && k < 200) begin
         drv();
         REQ_VALID[2] = ~REQ_VALID[2];
         tick();
         k++;
      end
      chk("t3_seen", 32'(RES_VALID != '0), 32'd1);
      chk("t3_res", 32'(RES_VALID), 32'b0100);
      chk("t3_zeros", 32'(RES_ZEROS), 32'd52);
      chk("t3_iv", 32'(n_iv), 32'd16);
      chk("t3_ack", 32'(n_ack), 32'd16);
      chk("t3_mirror", 32'(mirror_bad), 32'd0);
      drv();
      REQ = '0;
      REQ_VALID = '0;

      // timeout: model never answers
      m_lat = 0;
      do_reset();
      REQ_DATA[48 +: 16] = 16'h0001;
      REQ_VALID = 4'b1000;
      REQ = 4'b1000;
      clr();
      wait_res("t4", 300);
      chk("t4_res", 32'(RES_VALID), 32'b1000);
      chk("t4_zeros", 32'(RES_ZEROS), 32'd0);
      chk("t4_err", 32'(RES_ERR), 32'd1);
      chk("t4_lat", 32'(t_res - t_last_iv), 32'd65);
      drv();
      REQ = '0;
      REQ_VALID = '0;
      tick();
      chk("t4_idle", 32'(BUSY), 32'd0);
      m_lat = 2;

      // abort of requester 1 after 5 words
      do_reset();
      REQ_DATA[16 +: 16] = 16'h2222;
      REQ_VALID = 4'b0010;
      REQ = 4'b0110;
      clr();
      k = 0;
      while (n_ack < 5 && k < 100) begin
         tick();
         k++;
      end
      chk("t5_acks", 32'(n_ack), 32'd5);
      drv();
      REQ[1] = 1'b0;
      REQ_VALID = '0;
      k = 0;
      seen_idle = 1'b0;
      while (GNT != 4'b0100 && k < 100) begin
         tick();
         if (!BUSY) seen_idle = 1'b1;
         k++;
      end
      chk("t5_next_gnt", 32'(GNT), 32'b0100);
      chk("t5_nres", 32'(n_res), 32'd0);
      chk("t5_ack_total", 32'(n_ack), 32'd5);
      chk("t5_iv", 32'(n_iv), 32'd16);
      chk("t5_pads", 32'(n_z), 32'd11);
      chk("t5_words", 32'(n_nz), 32'd5);
      chk("t5_idle", 32'(seen_idle), 32'd1);
      drv();
      REQ_DATA[32 +: 16] = 16'h00F0;
      REQ_VALID = 4'b0100;
      wait_res("t5b", 200);
      chk("t5b_res", 32'(RES_VALID), 32'b0100);
      chk("t5b_zeros", 32'(RES_ZEROS), 32'd52);
      drv();
      REQ = '0;
      REQ_VALID = '0;

      // reset during FEED at word 7
      do_reset();
      REQ_DATA[0 +: 16] = 16'h8000;
      REQ_MODE = 4'b0001;
      REQ_VALID = 4'b0001;
      REQ = 4'b0001;
      clr();
      k = 0;
      while (n_ack < 7 && k < 100) begin
         tick();
         k++;
      end
      chk("t6_acks", 32'(n_ack), 32'd7);
      RST_N = 1'b0;
      #1;
      chk_zero("t6");
      drv();
      drv();
      RST_N = 1'b1;
      clr();
      wait_res("t6b", 200);
      chk("t6b_res", 32'(RES_VALID), 32'b0001);
      chk("t6b_zeros", 32'(RES_ZEROS), 32'd52);
      chk("t6b_ack", 32'(n_ack), 32'd16);
      chk("t6b_iv", 32'(n_iv), 32'd16);
      drv();
      REQ = '0;
      REQ_VALID = '0;
      repeat (3) drv();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/lzc_sched.md
Name: lzc_sched

Overview:
- Round-robin scheduler that shares one LZC datapath (CLK/RST_N/IVALID/DATA/MODE -> OVALID/ZEROS) between NREQ requesters.
- Grants one requester per job and streams exactly WORD words from it into the LZC with that requester's mode.
- Waits for the LZC result and returns ZEROS to the owning requester.
- Sits between client blocks and the single LZC instance.

Parameters:
- WIDTH, 16, bits per data word (matches LZC DATA).
- WORD, 16, words per LZC job.
- NREQ, 4, number of requesters (2..8).
- ZW, 9, ZEROS width (max 256 = WORD*WIDTH).
- TMO, 64, cycles allowed in WAIT before timeout.

Ports:
- CLK  in  1  clock, rising edge.
- RST_N  in  1  asynchronous active-low reset.
- REQ  in  NREQ  requester i wants a job; held high until its RES_VALID.
- REQ_MODE  in  NREQ  mode bit of requester i; sampled at grant.
- REQ_VALID  in  NREQ  requester i presents a word this cycle.
- REQ_DATA  in  NREQ*WIDTH  word of requester i at slice [i*WIDTH +: WIDTH].
- GNT  out  NREQ  one-hot grant, high from grant until job end.
- WORD_ACK  out  NREQ  pulse: requester i's word taken this cycle.
- L_IVALID  out  1  to LZC IVALID.
- L_DATA  out  WIDTH  to LZC DATA.
- L_MODE  out  1  to LZC MODE.
- L_OVALID  in  1  from LZC OVALID.
- L_ZEROS  in  ZW  from LZC ZEROS.
- RES_VALID  out  NREQ  one-hot one-cycle result pulse.
- RES_ZEROS  out  ZW  result value, valid with RES_VALID.
- RES_ERR  out  1  timeout flag, valid with RES_VALID.
- BUSY  out  1  state != IDLE.

Behaviour:
- Reset (async, RST_N=0): all outputs 0, state IDLE, word counter 0, timer 0. RR pointer is set so requester 0 has top priority.
- States: IDLE, FEED, WAIT, PAD, DONE.
- IDLE: if any REQ, pick the first set bit searching from ptr+1 upward, wrapping.
  - Next cycle: GNT one-hot, mode latched, ptr = winner, state FEED. Grant latency is 1 cycle.
- FEED: transfer when GNT[i] & REQ_VALID[i].
  - WORD_ACK[i] is combinational in the same cycle.
  - L_IVALID=1, L_DATA=word, L_MODE=latched mode are registered one cycle later.
  - No transfer means L_IVALID=0 (bubbles allowed); L_DATA holds its last value.
  - Counter increments per transfer. On the WORD-th transfer: state WAIT, timer cleared.
- L_MODE stays constant for the whole job, including WAIT.
- REQ[i] drops during FEED (abort): stop ACKing and go to PAD.
- PAD: issue the remaining WORD-count words with L_DATA=0, one per cycle, keeping the LZC frame aligned, then WAIT with a discard flag set.
- WAIT: timer increments each cycle.
  - L_OVALID=1: capture L_ZEROS, go to DONE.
  - Timer reaches TMO: capture ZEROS=0 with err=1, go to DONE.
- DONE (1 cycle): RES_VALID[i]=1 (unless discard), RES_ZEROS and RES_ERR driven. GNT cleared; next state IDLE.
- Back-to-back: the earliest next grant is the cycle after DONE.
- L_OVALID outside WAIT is ignored, with no side effects.
- REQ_VALID of non-granted requesters is ignored. REQ changes on non-granted lines only affect the next arbitration.
- A single requester holding REQ re-wins every arbitration. With all REQ high, grants rotate 0,1,2,3,0...
- Counter width: clog2(WORD+1). Timer width: clog2(TMO+1). Counter saturation is not required.
- Reset mid-job: everything returns to reset values immediately. The LZC shares RST_N, so frames stay aligned.

Decomposition:
- lzc_pkg holds:
  - state enum (IDLE, FEED, WAIT, PAD, DONE);
  - default WIDTH/WORD/ZW;
  - clog2-based counter-width constants.
- Sub-module rr_arbiter, parameter NREQ: inputs req and ptr, output one-hot winner, combinational.

Test Plan:
- Single job: REQ[0]=1, REQ_MODE[0]=1, REQ_VALID[0] continuous for 16 words; LZC model returns 9'd52 two cycles after the last word.
  - Expect 16 consecutive L_IVALID with L_MODE=1, then RES_VALID=4'b0001, RES_ZEROS=52, RES_ERR=0.
- Rotation: REQ=4'b1111 from reset.
  - Expect GNT order 0001, 0010, 0100, 1000, 0001, each with WORD_ACK count = 16 and the matching RES_VALID bit.
- Bubbles: REQ_VALID[2] toggles every other cycle.
  - Expect L_IVALID to mirror the toggles delayed by 1 cycle, exactly 16 pulses, result still returned to requester 2.
- Timeout: model never asserts OVALID, TMO=64.
  - Expect RES_VALID one-hot 65 cycles after WAIT entry, RES_ZEROS=0, RES_ERR=1, then BUSY=0.
- Abort: REQ[1] drops after 5 words.
  - Expect 11 padded L_IVALID cycles with L_DATA=0, then no RES_VALID, BUSY=0, and the next requester is granted.
- Reset: assert RST_N=0 during FEED at word 7.
  - Expect all outputs 0 asynchronously, and a fresh job after release starts at word count 0.
